// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock with a registered inter-chunk carry.
// Optional SEQ_CHUNK_ADDER_SUB_EN adds a 'sub' input selecting a-b (cout = NOT borrow).
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_n;
  logic [IDXW-1:0]   idx_q, idx_n;
  logic              carry_q, carry_n;
  logic [WIDTH-1:0]  a_q, a_n;
  logic [WIDTH-1:0]  b_q, b_n;
  logic [WIDTH-1:0]  part_q, part_n;
  logic [WIDTH-1:0]  sum_n;
  logic              cout_n;
  logic              busy_n;
  logic              done_n;

  // Current chunk datapath: one narrow adder shared across all chunks
  int unsigned       sh;
  logic [CHUNK-1:0]  ca, cb;
  logic [CHUNK:0]    csum;
  logic [WIDTH-1:0]  slice;

  always_comb begin
    sh    = 32'(idx_q) * CHUNK;
    ca    = CHUNK'(a_q >> sh);
    cb    = CHUNK'(b_q >> sh);
    csum  = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry_q};
    slice = WIDTH'(csum[CHUNK-1:0]) << sh;
  end

  // Next-state and output logic
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    carry_n = carry_q;
    a_n     = a_q;
    b_n     = b_q;
    part_n  = part_q;
    sum_n   = sum;
    cout_n  = cout;
    busy_n  = busy;
    done_n  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          a_n     = a;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
          b_n     = sub ? ~b : b;
          carry_n = sub ? 1'b1 : cin;
`else
          b_n     = b;
          carry_n = cin;
`endif
          idx_n   = '0;
          part_n  = '0;
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        carry_n = csum[CHUNK];
        part_n  = part_q | slice;
        idx_n   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NCHUNK - 1)) begin
          state_n = IDLE;
          idx_n   = '0;
          sum_n   = part_q | slice;
          cout_n  = csum[CHUNK];
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      carry_q <= carry_n;
      a_q     <= a_n;
      b_q     <= b_n;
      part_q  <= part_n;
      sum     <= sum_n;
      cout    <= cout_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: CHUNK=8 and CHUNK=32 instances against an arithmetic model.
module tb_seq_chunk_adder;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start8 = 1'b0;
  logic         startw = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy8, done8, cout8, busyw, donew, coutw;
  logic [W-1:0] sum8, sumw;

  int n_checks = 0;
  int n_fail   = 0;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .cin(cin),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  seq_chunk_adder #(.WIDTH(W), .CHUNK(32)) dutw (
    .clk(clk), .rst(rst), .start(startw), .a(a), .b(b), .cin(cin),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busyw), .done(donew), .sum(sumw), .cout(coutw)
  );

  always #5 clk = ~clk;

  // Reference: {cout, sum} of a+b+cin, or {a>=b, a-b} when subtracting
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    if (s) return {(x >= y), x - y};
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Issues one operation and reports latency, result hold and busy behaviour (no checks here)
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input bit wide, input bit poke,
                        output int lat, output bit held, output bit busy_ok);
    logic [W-1:0] old_sum;
    logic         old_cout;
    old_sum  = wide ? sumw : sum8;
    old_cout = wide ? coutw : cout8;
    a = x; b = y; cin = c;
    if (wide) startw = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; startw = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
    held    = 1'b1;
    busy_ok = ((wide ? busyw : busy8) === 1'b1);
    lat     = 0;
    for (int i = 1; i <= 64; i++) begin
      if (poke) begin
        a = '1; b = '1;
        if (wide) startw = 1'b1; else start8 = 1'b1;
      end
      @(posedge clk); #1;
      start8 = 1'b0; startw = 1'b0;
      if ((wide ? donew : done8) === 1'b1) begin
        lat = i;
        break;
      end
      if ((wide ? sumw : sum8) !== old_sum || (wide ? coutw : cout8) !== old_cout) held = 1'b0;
      if ((wide ? busyw : busy8) !== 1'b1) busy_ok = 1'b0;
    end
    if ((wide ? busyw : busy8) !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== '0) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b done=%b cout=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
    end
    n_checks++;
    if ({busyw, donew, coutw, sumw} !== '0) begin
      n_fail++;
      $display("FAIL resetw: got busy=%b done=%b cout=%b sum=%h, want all 0", busyw, donew, coutw, sumw);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; bit held, bok;
    run_op(32'h12345678, 32'h11111111, 1'b1, 1'b0, 1'b0, lat, held, bok);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
    n_checks++;
    if (!bok) begin n_fail++; $display("FAIL basic_busy: got busy profile bad, want high 4 cycles"); end
    n_checks++;
    if ({cout8, sum8} !== {1'b0, 32'h2345678A}) begin
      n_fail++; $display("FAIL basic_sum: got %b/%h want 0/2345678a", cout8, sum8);
    end
  endtask

  task automatic test_ripple();
    int lat; bit held, bok;
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, lat, held, bok);
    n_checks++;
    if (!held) begin n_fail++; $display("FAIL ripple_hold: got sum changed mid-op, want old value held"); end
    n_checks++;
    if ({cout8, sum8} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL ripple_sum: got %b/%h want 1/00000000", cout8, sum8);
    end
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL ripple_latency: got %0d want 4", lat); end
  endtask

  task automatic test_idle_reset();
    int lat; bit held, bok;
    run_op(32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0, 1'b0, lat, held, bok);
    #2; rst = 1'b1; #1;
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== '0) begin
      n_fail++;
      $display("FAIL idle_reset_async: got busy=%b done=%b cout=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
    end
    #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; bit held, bok;
    run_op(32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0, 1'b1, lat, held, bok);
    n_checks++;
    if ({cout8, sum8} !== {1'b0, 32'h10101010} || lat != 4) begin
      n_fail++; $display("FAIL busy_ignore: got %b/%h lat=%0d want 0/10101010 lat=4", cout8, sum8, lat);
    end
    run_op(32'h1, 32'h2, 1'b0, 1'b0, 1'b0, lat, held, bok);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    n_checks++;
    if ({cout8, sum8} !== {1'b0, 32'h3}) begin
      n_fail++; $display("FAIL b2b_sum: got %b/%h want 0/00000003", cout8, sum8);
    end
  endtask

  task automatic test_reset_run();
    int lat, pulses; bit held, bok;
    a = 32'hAAAA5555; b = 32'h12345678; cin = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1; #1;
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== '0) begin
      n_fail++;
      $display("FAIL run_reset: got busy=%b done=%b cout=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
    end
    @(posedge clk); #1; rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL run_reset_nodone: got %0d done/busy cycles want 0", pulses); end
    run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, lat, held, bok);
    n_checks++;
    if ({cout8, sum8} !== {1'b0, 32'h00010000} || lat != 4) begin
      n_fail++; $display("FAIL post_reset_sum: got %b/%h lat=%0d want 0/00010000 lat=4", cout8, sum8, lat);
    end
  endtask

  task automatic test_random();
    int lat; bit held, bok;
    logic [W-1:0] x, y; logic c, s, wide;
    logic [W:0] exp;
    for (int i = 0; i < 30; i++) begin
      x = $urandom; y = $urandom; c = 1'($urandom); wide = (i % 3 == 2);
      if (i % 5 == 0) y = ~x;
      s = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      s = 1'($urandom); sub = s;
`endif
      exp = model(x, y, c, s);
      run_op(x, y, c, wide, 1'b0, lat, held, bok);
      n_checks++;
      if ((wide ? {coutw, sumw} : {cout8, sum8}) !== exp) begin
        n_fail++;
        $display("FAIL random_%0d: got %h want %h (a=%h b=%h cin=%b sub=%b wide=%b)",
                 i, wide ? {coutw, sumw} : {cout8, sum8}, exp, x, y, c, s, wide);
      end
      n_checks++;
      if (lat != (wide ? 1 : 4) || !bok) begin
        n_fail++; $display("FAIL random_lat_%0d: got lat=%0d busy_ok=%b want lat=%0d busy_ok=1", i, lat, bok, wide ? 1 : 4);
      end
    end
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    sub = 1'b0;
`endif
  endtask

  task automatic test_wide();
    int lat; bit held, bok;
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b0, lat, held, bok);
    n_checks++;
    if ({coutw, sumw} !== {1'b1, 32'h0} || lat != 1) begin
      n_fail++; $display("FAIL wide_carry: got %b/%h lat=%0d want 1/00000000 lat=1", coutw, sumw, lat);
    end
  endtask

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  task automatic test_sub();
    int lat; bit held, bok;
    for (int w = 0; w < 2; w++) begin
      sub = 1'b1;
      run_op(32'd5, 32'd7, 1'b0, w[0], 1'b0, lat, held, bok);
      n_checks++;
      if ((w[0] ? {coutw, sumw} : {cout8, sum8}) !== {1'b0, 32'hFFFFFFFE} || lat != (w[0] ? 1 : 4)) begin
        n_fail++; $display("FAIL sub_5_7_w%0d: got %h lat=%0d want 0fffffffe", w, w[0] ? {coutw, sumw} : {cout8, sum8}, lat);
      end
      sub = 1'b1;
      run_op(32'd7, 32'd5, 1'b0, w[0], 1'b0, lat, held, bok);
      n_checks++;
      if ((w[0] ? {coutw, sumw} : {cout8, sum8}) !== {1'b1, 32'h2} || lat != (w[0] ? 1 : 4)) begin
        n_fail++; $display("FAIL sub_7_5_w%0d: got %h lat=%0d want 100000002", w, w[0] ? {coutw, sumw} : {cout8, sum8}, lat);
      end
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_idle_reset();
    test_back_to_back();
    test_reset_run();
    test_wide();
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
